// File: rtl/rd_master.sv
// rd_master -- Avalon-MM pipelined read master with credit-bounded response buffer.
//
// Pops word addresses from a show-ahead address FIFO, issues pipelined
// reads to the memory bridge, and streams the returned words in issue order
// over a valid/ready interface. The number of pending reads (in flight,
// buffered, or currently being requested) never exceeds RSP_DEPTH, so the
// response buffer cannot overflow.
//
// Optional feature macro: RD_MASTER_STATS_EN adds stats_clear, words_cnt and
// stall_cnt (saturating delivered-word and waitrequest-stall counters).
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   enable                permits issuing new reads
//   fifo_empty, fifo_out  address FIFO status and head word address
//   fifo_rdreq            FIFO pop strobe (same cycle as the fetch)
//   avm_*                 Avalon-MM read master
//   out_data/valid/ready  response stream
//   busy                  requests pending, in flight or buffered
//   stats_clear, words_cnt, stall_cnt   (RD_MASTER_STATS_EN only)
module rd_master #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_out,
  output logic        fifo_rdreq,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
`ifdef RD_MASTER_STATS_EN
  ,
  input  logic        stats_clear,
  output logic [31:0] words_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   occ;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [31:0]     mem [RSP_DEPTH];

  logic [CW:0]     pending;
  logic            fetch_ok;
  logic            accept;
  logic            fetch;
  logic            pop;
  logic            rsp_wr;

  // Credit check uses registered counts only, so out_ready never reaches
  // fetch/avm_read combinationally; a pop frees its credit next cycle.
  // In REQ the outstanding request already holds one credit, which carries
  // over to in-flight on accept, so the same comparison covers back-to-back.
  assign pending  = {1'b0, inflight} + {1'b0, occ} + {{CW{1'b0}}, (state == REQ)};
  assign fetch_ok = enable && !fifo_empty && (pending < {1'b0, DEPTH_C});
  assign accept   = (state == REQ) && !avm_waitrequest;
  assign fetch    = reset && fetch_ok && ((state == IDLE) || accept);

  assign fifo_rdreq = fetch;

  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign pop       = out_valid && out_ready;

  // Stray readdatavalid (nothing in flight, e.g. after reset) is dropped;
  // the full-and-no-pop guard only protects against a misbehaving slave.
  assign rsp_wr = avm_readdatavalid && (inflight != '0) && ((occ != DEPTH_C) || pop);

  assign busy = (state == REQ) || (inflight != '0) || (occ != '0);

  // Request stage: FSM with registered avm_read/avm_address
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      avm_read    <= 1'b0;
      avm_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch) begin
            avm_address <= fifo_out & 32'hFFFF_FFFC;
            avm_read    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            if (fetch) begin
              avm_address <= fifo_out & 32'hFFFF_FFFC;
            end else begin
              avm_read <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

  // Response stage: credit counters and buffer pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case ({accept, rsp_wr})
        2'b10:   inflight <= inflight + ONE_C;
        2'b01:   inflight <= inflight - ONE_C;
        default: inflight <= inflight;
      endcase
      case ({rsp_wr, pop})
        2'b10:   occ <= occ + ONE_C;
        2'b01:   occ <= occ - ONE_C;
        default: occ <= occ;
      endcase
      if (rsp_wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Buffer storage carries data only; validity comes from occ.
  always_ff @(posedge clk) begin
    if (rsp_wr) mem[wr_ptr] <= avm_readdata;
  end

`ifdef RD_MASTER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      words_cnt <= '0;
      stall_cnt <= '0;
    end else if (stats_clear) begin
      words_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop)                         words_cnt <= sat_inc(words_cnt);
      if (avm_read && avm_waitrequest) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rd_master.sv
// tb_rd_master -- directed self-checking bench for rd_master.
// Contains a show-ahead address FIFO model and an Avalon slave that returns
// readdata = address ^ 32'hDA7A_0000 two cycles after each accepted read.
// Inputs change at negedge+1; DUT behaviour is sampled at negedge+2.
module tb_rd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [31:0] fifo_out;
  logic        fifo_rdreq;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef RD_MASTER_STATS_EN
  logic        stats_clear;
  logic [31:0] words_cnt;
  logic [31:0] stall_cnt;
`endif

  rd_master #(.RSP_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_out(fifo_out),
    .fifo_rdreq(fifo_rdreq),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy)
`ifdef RD_MASTER_STATS_EN
    ,
    .stats_clear(stats_clear),
    .words_cnt(words_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] fq[$];       // address FIFO contents
  rsp_t        sq[$];       // slave responses awaiting return
  logic [31:0] acc_q[$];    // accepted read addresses
  int          acc_cyc[$];  // cycle of each accept
  logic [31:0] out_q[$];    // delivered stream words
  int          out_cyc[$];  // cycle of each handshake
  logic [31:0] stall_q[$];  // avm_address on each stalled cycle
  int          pops;
  int          stall_left;
  int          cyc;
  logic        pop_pend;

  int n_chk;
  int n_pass;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic clear_rec();
    acc_q.delete();
    acc_cyc.delete();
    out_q.delete();
    out_cyc.delete();
    stall_q.delete();
    pops = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic wait_out(input int n, input int limit);
    for (int i = 0; i < limit && out_q.size() < n; i++) cycles(1);
  endtask

  // FIFO + slave model
  initial begin
    cyc = 0;
    pop_pend = 1'b0;
    stall_left = 0;
    pops = 0;
    fifo_empty = 1'b1;
    fifo_out = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (pop_pend && fq.size() > 0) begin
        void'(fq.pop_front());
        pops++;
      end
      fifo_empty = (fq.size() == 0);
      fifo_out   = (fq.size() == 0) ? 32'h0 : fq[0];
      if (sq.size() > 0 && sq[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = sq[0].d;
        void'(sq.pop_front());
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
      end
      avm_waitrequest = (stall_left > 0);
      #1;
      pop_pend = fifo_rdreq;
      if (avm_read && !avm_waitrequest) begin
        sq.push_back('{due: cyc + 2, d: avm_address ^ 32'hDA7A_0000});
        acc_q.push_back(avm_address);
        acc_cyc.push_back(cyc);
      end
      if (avm_read && avm_waitrequest) begin
        stall_left--;
        stall_q.push_back(avm_address);
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        out_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
`ifdef RD_MASTER_STATS_EN
    stats_clear = 1'b0;
`endif
    cycles(3);

    // reset values
    check_val("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check_val("rst_read", 32'(avm_read), 32'd0);
    check_val("rst_addr", avm_address, 32'h0);
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_data", out_data, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
`ifdef RD_MASTER_STATS_EN
    check_val("rst_words", words_cnt, 32'd0);
    check_val("rst_stall", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    cycles(2);

    // three back-to-back reads
    clear_rec();
    @(negedge clk);
    fq.push_back(32'h100);
    fq.push_back(32'h104);
    fq.push_back(32'h108);
    #3;
    check_val("t1_rdreq_lat", 32'(fifo_rdreq), 32'd1);
    check_val("t1_read_before", 32'(avm_read), 32'd0);
    cycles(1);
    check_val("t1_read_lat", 32'(avm_read), 32'd1);
    check_val("t1_first_addr", avm_address, 32'h100);
    wait_out(3, 40);
    check_val("t1_count", 32'(out_q.size()), 32'd3);
    check_val("t1_d0", out_q[0], 32'hDA7A_0100);
    check_val("t1_d1", out_q[1], 32'hDA7A_0104);
    check_val("t1_d2", out_q[2], 32'hDA7A_0108);
    check_val("t1_a1", acc_q[1], 32'h104);
    check_val("t1_a2", acc_q[2], 32'h108);
    check_val("t1_b2b_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    check_val("t1_b2b_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd1);
    check_val("t1_data_lat", 32'(out_cyc[0] - acc_cyc[0]), 32'd3);
    check_val("t1_pops", 32'(pops), 32'd3);
    cycles(1);
    check_val("t1_busy_end", 32'(busy), 32'd0);

    // credit limit with stalled output
    clear_rec();
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) fq.push_back(32'h500 + 32'(4 * i));
    cycles(20);
    check_val("t2_reads_held", 32'(acc_q.size()), 32'd4);
    check_val("t2_pops_held", 32'(pops), 32'd4);
    check_val("t2_valid", 32'(out_valid), 32'd1);
    check_val("t2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_out(8, 100);
    check_val("t2_count", 32'(out_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("t2_d%0d", i), out_q[i], 32'hDA7A_0500 + 32'(4 * i));
    check_val("t2_pops", 32'(pops), 32'd8);

    // waitrequest stall on the first read
    clear_rec();
`ifdef RD_MASTER_STATS_EN
    @(negedge clk);
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    #3;
    check_val("t3_clr_words", words_cnt, 32'd0);
`endif
    @(negedge clk);
    stall_left = 5;
    fq.push_back(32'h300);
    wait_out(1, 40);
    cycles(2);
    check_val("t3_stall_cycles", 32'(stall_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check_val($sformatf("t3_hold%0d", i), stall_q[i], 32'h300);
    check_val("t3_pops", 32'(pops), 32'd1);
    check_val("t3_acc", acc_q[0], 32'h300);
    check_val("t3_data", out_q[0], 32'hDA7A_0300);
`ifdef RD_MASTER_STATS_EN
    check_val("t3_stall_cnt", stall_cnt, 32'd5);
    check_val("t3_words_cnt", words_cnt, 32'd1);
`endif

    // unaligned FIFO address
    clear_rec();
    @(negedge clk);
    fq.push_back(32'h203);
    wait_out(1, 40);
    check_val("t4_addr", acc_q[0], 32'h200);
    check_val("t4_data", out_q[0], 32'hDA7A_0200);

    // enable dropped during a stalled request
    clear_rec();
    @(negedge clk);
    stall_left = 4;
    fq.push_back(32'h400);
    fq.push_back(32'h404);
    #3;
    check_val("t5_rdreq", 32'(fifo_rdreq), 32'd1);
    @(negedge clk);
    enable = 1'b0;
    cycles(15);
    check_val("t5_pops", 32'(pops), 32'd1);
    check_val("t5_reads", 32'(acc_q.size()), 32'd1);
    check_val("t5_acc", acc_q[0], 32'h400);
    check_val("t5_count", 32'(out_q.size()), 32'd1);
    check_val("t5_data", out_q[0], 32'hDA7A_0400);
    check_val("t5_fifo_left", 32'(fq.size()), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    enable = 1'b1;
    wait_out(2, 40);
    check_val("t5_resume", out_q[1], 32'hDA7A_0404);

    // reset with two reads in flight
    clear_rec();
    @(negedge clk);
    fq.push_back(32'h600);
    fq.push_back(32'h604);
    #3;
    for (int i = 0; i < 20 && acc_q.size() < 2; i++) cycles(1);
    check_val("t6_inflight", 32'(acc_q.size()), 32'd2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #3;
    check_val("t6_rdreq", 32'(fifo_rdreq), 32'd0);
    check_val("t6_read", 32'(avm_read), 32'd0);
    check_val("t6_addr", avm_address, 32'h0);
    check_val("t6_valid", 32'(out_valid), 32'd0);
    check_val("t6_data", out_data, 32'h0);
    check_val("t6_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      check_val($sformatf("t6_late%0d", i), 32'(out_valid), 32'd0);
    end
    check_val("t6_no_words", 32'(out_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rd_master.md
# rd_master

Avalon-MM read master directly downstream of the read controller's address FIFO. It pops 32-bit word addresses from the show-ahead FIFO, issues pipelined reads to the HPS memory bridge, and streams the returned data words, in order, to the packet-capture datapath over a valid/ready interface. A credit scheme bounds outstanding reads so returned data can never overflow the internal response buffer.

## Interface
Parameters:
- RSP_DEPTH, 4: response buffer depth and maximum in-flight reads; power of two, 2..64.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- enable  in  1  permits issuing new reads
- fifo_empty  in  1  address FIFO empty
- fifo_out  in  32  show-ahead FIFO head (word address)
- fifo_rdreq  out  1  FIFO pop strobe
- avm_address  out  32  read address, bits [1:0] forced 0
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data valid
- out_data  out  32  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- busy  out  1  reads pending, in flight or buffered
- stats_clear  in  1  clear counters (RD_MASTER_STATS_EN only)
- words_cnt  out  32  words delivered (RD_MASTER_STATS_EN only)
- stall_cnt  out  32  waitrequest stall cycles (RD_MASTER_STATS_EN only)

## Operation
- FSM states: IDLE, REQ.
- pending = in-flight reads + buffer occupancy + (state==REQ). The block may fetch a new address only when enable && !fifo_empty && pending < RSP_DEPTH.
- A fetch registers fifo_out into avm_address with [1:0]=0 and pulses fifo_rdreq for exactly that cycle.
- IDLE: on fetch, go to REQ. Otherwise stay in IDLE.
- REQ: avm_read=1, with address held stable while avm_waitrequest=1. On accept (avm_waitrequest=0), in-flight count +1. If a fetch is possible in the same cycle, counting the accepted read as in-flight, fetch and stay in REQ (back-to-back reads). Otherwise go to IDLE.
- Dropping enable while in REQ does not abort the current request. It completes, then no further fetches occur.
- avm_readdatavalid: write avm_readdata into the response FIFO and decrement the in-flight count. Data order equals issue order.
- out_valid = buffer non-empty. out_data = buffer head. Pop on out_valid && out_ready.
- Simultaneous write and pop is legal at any occupancy, including full. Occupancy is unchanged in that case.
- The credit scheme guarantees readdatavalid never arrives with the buffer full and no pop. An unexpected readdatavalid with zero in flight is ignored.
- busy = (state==REQ) || in-flight>0 || occupancy>0.
- Counters are $clog2(RSP_DEPTH)+1 bits wide. Read and write pointers wrap modulo RSP_DEPTH.

## Timing
- Reset values: fifo_rdreq=0, avm_read=0, avm_address=0, out_valid=0, out_data=0, busy=0, counters=0, state IDLE. Reset mid-transfer discards in-flight and buffered data. Late readdatavalid after reset is ignored.
- Fetch latency: fifo_empty falls in cycle N (IDLE, credit available) → fifo_rdreq=1 in N → avm_read=1 from N+1.
- Sustained rate is 1 read/cycle with zero waitrequest, enough credits and a non-empty FIFO.
- Data latency: avm_readdatavalid in cycle M → out_valid=1 in M+1 (registered buffer, no combinational bypass).
- out_ready has no combinational path to avm_read or fifo_rdreq. Credits freed by a pop in cycle P become usable in P+1.

## Configuration
- RD_MASTER_STATS_EN defined:
  - words_cnt increments on each out handshake.
  - stall_cnt increments on each cycle with avm_read && avm_waitrequest.
  - Both counters saturate at 32'hFFFF_FFFF.
  - stats_clear zeroes both next cycle and wins over a simultaneous increment.
- RD_MASTER_STATS_EN undefined: stats_clear, words_cnt and stall_cnt ports and logic are absent. Behaviour is otherwise identical.

## Test plan
- FIFO holds 0x100, 0x104, 0x108; no waitrequest; readdata returned 2 cycles later; out_ready=1 → three back-to-back reads with avm_address 0x100/0x104/0x108; out_data in order; busy falls after the last handshake.
- out_ready=0, RSP_DEPTH=4, FIFO holds 8 addresses → exactly 4 reads issued and 4 pops; out_ready=1 then resumes all 8 reads, no data lost.
- avm_waitrequest=1 for 5 cycles on the first read → avm_address stable for those 5 cycles; fifo_rdreq pulses once; stall_cnt=5 (with RD_MASTER_STATS_EN).
- fifo_out=0x203 → avm_address=0x200.
- enable deasserted during REQ with a stalled request → the request completes, data is delivered, no further fetches occur, FIFO not popped again.
- reset asserted with 2 reads in flight → all outputs return to their reset values next cycle; the following readdatavalid pulses produce no out_valid.
